// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared types and constants for the pong game controller:
//               FSM state encoding, raster geometry and scoring defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    // Game FSM state encoding, also exported on the debug state port
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // Raster coordinate width
    localparam int c_coord_w = 10;

    // Raster position that marks the end of a frame (first pixel of line 481)
    localparam logic [c_coord_w-1:0] c_frame_end_x = 10'd0;
    localparam logic [c_coord_w-1:0] c_frame_end_y = 10'd481;

    // Default winning score
    localparam int c_default_win_score = 9;

    // Frame counter width
    localparam int c_frame_cnt_w = 8;

    // Score increment that sticks at the limit instead of wrapping
    function automatic logic [3:0] sat_inc(input logic [3:0] value,
                                           input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage : pong_pkg
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : frame_timer
// Description : Counts frame ticks while enabled. A load clears the count and
//               latches a new target; done flags the tick that matches the
//               target (i.e. the TARGET+1-th tick since the load).
// Revision    : 1.0 - initial release
// ============================================================================
module frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] target,
    input  logic             enable,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_target;

    // Count ticks; a load wins over a coincident tick so the entry tick is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_target <= '0;
        end else if (load) begin
            r_count  <= '0;
            r_target <= target;
        end else if (enable && tick) begin
            r_count  <= r_count + 1'b1;
        end
    end

    assign done = enable && tick && (r_count == r_target);

endmodule : frame_timer
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl
// Description : Pong game sequencer. Holds the ball during serve and point
//               pauses, launches it after a fixed number of frames, keeps the
//               score and declares a winner.
// Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = c_default_win_score,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic                 clk25M,
    input  logic                 reset,
    input  logic [c_coord_w-1:0] x,
    input  logic [c_coord_w-1:0] y,
    input  logic                 start_btn,
    input  logic                 miss_left,
    input  logic                 miss_right,
    output logic                 ball_hold,
    output logic                 ball_launch,
    output logic                 serve_dir,
    output logic [3:0]           score_l,
    output logic [3:0]           score_r,
    output logic                 game_over,
    output logic                 winner,
    output logic [2:0]           state
);

    localparam logic [3:0]               c_win       = 4'(WIN_SCORE);
    localparam logic [c_frame_cnt_w-1:0] c_serve_tgt = c_frame_cnt_w'(SERVE_FRAMES - 1);
    localparam logic [c_frame_cnt_w-1:0] c_point_tgt = c_frame_cnt_w'(POINT_FRAMES - 1);

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic                     r_start_q;
    logic                     w_start_rise;
    logic                     w_frame_tick;
    logic [3:0]               r_score_l;
    logic [3:0]               r_score_r;
    logic [3:0]               w_score_l_nxt;
    logic [3:0]               w_score_r_nxt;
    logic                     r_serve_dir;
    logic                     w_serve_dir_nxt;
    logic                     r_hold;
    logic                     r_launch;
    logic                     w_launch_nxt;
    logic                     r_over;
    logic                     r_winner;
    logic                     w_timer_load;
    logic [c_frame_cnt_w-1:0] w_timer_tgt;
    logic                     w_timer_en;
    logic                     w_timer_done;

    assign w_start_rise = start_btn & ~r_start_q;
    assign w_frame_tick = (x == c_frame_end_x) && (y == c_frame_end_y);
    assign w_timer_en   = (r_state == ST_SERVE) || (r_state == ST_POINT);

    frame_timer #(
        .CNT_W (c_frame_cnt_w)
    ) u_frame_timer (
        .clk    (clk25M),
        .rst    (reset),
        .load   (w_timer_load),
        .target (w_timer_tgt),
        .enable (w_timer_en),
        .tick   (w_frame_tick),
        .done   (w_timer_done)
    );

    // Next-state, score and launch decisions
    always_comb begin
        w_state_nxt     = r_state;
        w_score_l_nxt   = r_score_l;
        w_score_r_nxt   = r_score_r;
        w_serve_dir_nxt = r_serve_dir;
        w_launch_nxt    = 1'b0;

        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (w_start_rise) begin
                    w_state_nxt     = ST_SERVE;
                    w_score_l_nxt   = 4'd0;
                    w_score_r_nxt   = 4'd0;
                    w_serve_dir_nxt = 1'b1;
                end
            end
            ST_SERVE: begin
                if (w_timer_done) begin
                    w_state_nxt  = ST_PLAY;
                    w_launch_nxt = 1'b1;
                end
            end
            ST_PLAY: begin
                // A double miss is a void rally: pause, but nobody scores
                if (miss_left && miss_right) begin
                    w_state_nxt     = ST_POINT;
                end else if (miss_left) begin
                    w_state_nxt     = ST_POINT;
                    w_score_r_nxt   = sat_inc(r_score_r, c_win);
                    w_serve_dir_nxt = 1'b0;
                end else if (miss_right) begin
                    w_state_nxt     = ST_POINT;
                    w_score_l_nxt   = sat_inc(r_score_l, c_win);
                    w_serve_dir_nxt = 1'b1;
                end
            end
            ST_POINT: begin
                if (w_timer_done) begin
                    if ((r_score_l == c_win) || (r_score_r == c_win)) begin
                        w_state_nxt = ST_OVER;
                    end else begin
                        w_state_nxt = ST_SERVE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Every state change restarts the frame timer for the new state
        w_timer_load = (w_state_nxt != r_state);
        w_timer_tgt  = (w_state_nxt == ST_POINT) ? c_point_tgt : c_serve_tgt;
    end

    // State, score and registered output updates
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_start_q   <= 1'b0;
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_serve_dir <= 1'b1;
            r_hold      <= 1'b1;
            r_launch    <= 1'b0;
            r_over      <= 1'b0;
            r_winner    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_start_q   <= start_btn;
            r_score_l   <= w_score_l_nxt;
            r_score_r   <= w_score_r_nxt;
            r_serve_dir <= w_serve_dir_nxt;
            r_hold      <= (w_state_nxt != ST_PLAY);
            r_launch    <= w_launch_nxt;
            r_over      <= (w_state_nxt == ST_OVER);
            r_winner    <= (w_state_nxt == ST_OVER) && (w_score_r_nxt == c_win);
        end
    end

    assign ball_hold   = r_hold;
    assign ball_launch = r_launch;
    assign serve_dir   = r_serve_dir;
    assign score_l     = r_score_l;
    assign score_r     = r_score_r;
    assign game_over   = r_over;
    assign winner      = r_winner;
    assign state       = r_state;

endmodule : game_ctrl
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_ctrl
// Description : Directed self-checking bench for game_ctrl with WIN_SCORE=3,
//               SERVE_FRAMES=2 and POINT_FRAMES=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    logic       clk25M     = 1'b0;
    logic       reset      = 1'b1;
    logic [9:0] x          = 10'd5;
    logic [9:0] y          = 10'd100;
    logic       start_btn  = 1'b0;
    logic       miss_left  = 1'b0;
    logic       miss_right = 1'b0;
    logic       ball_hold;
    logic       ball_launch;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    int tests  = 0;
    int failed = 0;

    game_ctrl #(
        .WIN_SCORE    (3),
        .SERVE_FRAMES (2),
        .POINT_FRAMES (2)
    ) dut (
        .clk25M      (clk25M),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .start_btn   (start_btn),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .ball_hold   (ball_hold),
        .ball_launch (ball_launch),
        .serve_dir   (serve_dir),
        .score_l     (score_l),
        .score_r     (score_r),
        .game_over   (game_over),
        .winner      (winner),
        .state       (state)
    );

    always #20 clk25M = ~clk25M;

    // Output snapshot: {state, score_l, score_r, serve_dir, hold, launch, over, winner}
    function automatic logic [15:0] dut_vec();
        return {state, score_l, score_r, serve_dir, ball_hold, ball_launch, game_over, winner};
    endfunction

    function automatic logic [15:0] pack_exp(input logic [2:0] st, input logic [3:0] sl,
                                             input logic [3:0] sr, input logic dir,
                                             input logic hold, input logic launch,
                                             input logic over, input logic win);
        return {st, sl, sr, dir, hold, launch, over, win};
    endfunction

    task automatic step();
        @(posedge clk25M);
        #1;
    endtask

    task automatic frame();
        x = 10'd0;
        y = 10'd481;
        step();
        x = 10'd5;
        y = 10'd100;
    endtask

    task automatic miss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        step();
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    // Miss, wait out the point pause and the serve; ends on the launch cycle
    task automatic rally(input logic l, input logic r);
        miss(l, r);
        repeat (4) frame();
    endtask

    task automatic test_reset();
        logic [15:0] e;
        reset = 1'b1;
        repeat (2) step();
        e = pack_exp(S_IDLE, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL reset_values: got %h want %h", dut_vec(), e); end
        reset = 1'b0;
        frame();
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL idle_stays: got %h want %h", dut_vec(), e); end
    endtask

    task automatic test_serve();
        logic [15:0] e;
        start_btn = 1'b1;
        step();
        e = pack_exp(S_SERVE, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL start_to_serve: got %h want %h", dut_vec(), e); end
        miss(1'b1, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL miss_in_serve: got %h want %h", dut_vec(), e); end
        x = 10'd1; y = 10'd481; step();
        x = 10'd0; y = 10'd480; step();
        x = 10'd5; y = 10'd100;
        frame();
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL near_tick_ignored: got %h want %h", dut_vec(), e); end
        frame();
        e = pack_exp(S_PLAY, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL serve_launch: got %h want %h", dut_vec(), e); end
        step();
        e = pack_exp(S_PLAY, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL launch_single: got %h want %h", dut_vec(), e); end
        start_btn = 1'b0;
    endtask

    task automatic test_point();
        logic [15:0] e;
        miss(1'b1, 1'b0);
        e = pack_exp(S_POINT, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL miss_left_point: got %h want %h", dut_vec(), e); end
        frame();
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL point_hold: got %h want %h", dut_vec(), e); end
        frame();
        e = pack_exp(S_SERVE, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL point_to_serve: got %h want %h", dut_vec(), e); end
        frame();
        frame();
        e = pack_exp(S_PLAY, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL relaunch_left: got %h want %h", dut_vec(), e); end
    endtask

    task automatic test_both_miss();
        logic [15:0] e;
        miss(1'b1, 1'b1);
        e = pack_exp(S_POINT, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL double_miss: got %h want %h", dut_vec(), e); end
        repeat (4) frame();
        e = pack_exp(S_PLAY, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL double_miss_resume: got %h want %h", dut_vec(), e); end
    endtask

    task automatic test_tick_on_transition();
        logic [15:0] e;
        miss_right = 1'b1;
        x = 10'd0; y = 10'd481;
        step();
        miss_right = 1'b0;
        x = 10'd5; y = 10'd100;
        e = pack_exp(S_POINT, 4'd1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL miss_right_point: got %h want %h", dut_vec(), e); end
        frame();
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL entry_tick_not_counted: got %h want %h", dut_vec(), e); end
        repeat (3) frame();
        e = pack_exp(S_PLAY, 4'd1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL relaunch_right: got %h want %h", dut_vec(), e); end
    endtask

    task automatic test_win();
        logic [15:0] e;
        rally(1'b0, 1'b1);
        miss(1'b0, 1'b1);
        e = pack_exp(S_POINT, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL third_point: got %h want %h", dut_vec(), e); end
        frame();
        frame();
        e = pack_exp(S_OVER, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL game_over_left: got %h want %h", dut_vec(), e); end
        miss(1'b0, 1'b1);
        miss(1'b1, 1'b0);
        frame();
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL over_ignores_miss: got %h want %h", dut_vec(), e); end
    endtask

    task automatic test_restart();
        logic [15:0] e;
        logic [2:0]  prev;
        int          restarts;
        restarts  = 0;
        prev      = state;
        start_btn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (prev != S_SERVE && state == S_SERVE) restarts++;
            prev = state;
        end
        tests++;
        if (restarts !== 1) begin failed++; $display("FAIL restart_count: got %0d want 1", restarts); end
        e = pack_exp(S_SERVE, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL restart_state: got %h want %h", dut_vec(), e); end
        frame();
        frame();
        e = pack_exp(S_PLAY, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL restart_launch: got %h want %h", dut_vec(), e); end
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        e = pack_exp(S_PLAY, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL start_in_play: got %h want %h", dut_vec(), e); end
    endtask

    task automatic test_reset_mid_game();
        logic [15:0] e;
        rally(1'b0, 1'b1);
        rally(1'b0, 1'b1);
        rally(1'b1, 1'b0);
        e = pack_exp(S_PLAY, 4'd2, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL score_2_1: got %h want %h", dut_vec(), e); end
        #5;
        reset = 1'b1;
        #1;
        e = pack_exp(S_IDLE, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL async_reset: got %h want %h", dut_vec(), e); end
        step();
        reset = 1'b0;
        step();
        miss(1'b1, 1'b0);
        tests++;
        if (dut_vec() !== e) begin failed++; $display("FAIL after_reset_idle: got %h want %h", dut_vec(), e); end
    endtask

    // Directed scenario sequence
    initial begin
        test_reset();
        test_serve();
        test_point();
        test_both_miss();
        test_tick_on_transition();
        test_win();
        test_restart();
        test_reset_mid_game();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_game_ctrl
`default_nettype wire

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 9, score that ends the game (range 1..15).
REQ-002 Parameter SERVE_FRAMES, default 60, frames the ball is held before launch (range 1..255).
REQ-003 Parameter POINT_FRAMES, default 30, frames of pause after a point (range 1..255).
REQ-004 clk25M  input  1  sole clock, 25 MHz pixel clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 x, y  input  10 each  current raster position.
REQ-007 start_btn  input  1  start request, already synchronized to clk25M, level.
REQ-008 miss_left, miss_right  input  1 each  ball passed the left or right boundary, one-cycle pulses.
REQ-009 ball_hold  output  1  forces the ball to centre and zero velocity while high.
REQ-010 ball_launch  output  1  one-cycle pulse that starts ball motion.
REQ-011 serve_dir  output  1  launch direction: 1 = right, 0 = left.
REQ-012 score_l, score_r  output  4 each  player scores.
REQ-013 game_over  output  1  high in OVER state.
REQ-014 winner  output  1  0 = left player won, 1 = right player won; valid while game_over.
REQ-015 state  output  3  current FSM state, for debug and display.

Function
REQ-016 frame_tick SHALL be high exactly when x==0 and y==481 (one cycle per frame).
REQ-017 FSM states: IDLE, SERVE, PLAY, POINT, OVER.
REQ-018 start_rise = start_btn & ~start_btn_q, where start_btn_q is a registered copy of start_btn.
REQ-019 IDLE→SERVE on start_rise: clear both scores, serve_dir=1, clear frame counter.
REQ-020 SERVE: ball_hold=1; count frame_ticks; on the tick where count==SERVE_FRAMES-1 → PLAY, and ball_launch is high for exactly the next cycle.
REQ-021 PLAY: ball_hold=0; miss_left → score_r+1, serve_dir=0, → POINT; miss_right → score_l+1, serve_dir=1, → POINT.
REQ-022 If miss_left and miss_right are high in the same cycle → POINT with no score change and serve_dir unchanged.
REQ-023 POINT: ball_hold=1; count POINT_FRAMES ticks; then → OVER if either score==WIN_SCORE, else → SERVE (counter cleared).
REQ-024 OVER: game_over=1; winner=1 if score_r==WIN_SCORE; ball_hold=1; start_rise → SERVE with scores cleared and serve_dir=1.
REQ-025 Ignore misses outside PLAY; ignore start_rise in SERVE, PLAY, and POINT.
REQ-026 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-027 Frame counter SHALL be 8 bits and cleared on every state entry.
REQ-028 All outputs SHALL be registered; a miss pulse is reflected in the score and state on the next clock edge.
REQ-029 A frame_tick coincident with a state transition SHALL NOT be counted in the new state.

Reset
REQ-030 On reset: state=IDLE, score_l=score_r=0, serve_dir=1, ball_hold=1, ball_launch=0, game_over=0, winner=0, counter=0, start_btn_q=0.
REQ-031 Reset mid-game SHALL abort immediately to the REQ-030 values, with no launch pulse emitted.

Structure
REQ-032 Shared package pong_pkg holds: the state encoding, the frame-end coordinates (0, 481), the 10-bit coordinate width, and the default WIN_SCORE.
REQ-033 One sub-module, frame_timer (tick counter with clear, load target, and done flag), instantiated once and shared by SERVE and POINT.

Verification
REQ-034 Reset, then start_btn high → state SERVE; after SERVE_FRAMES=2 ticks → ball_launch a single 1-cycle pulse, state PLAY, serve_dir=1.
REQ-035 In PLAY, one miss_left pulse → score_r=1, score_l=0, serve_dir=0, state POINT; after POINT_FRAMES=2 ticks → SERVE.
REQ-036 WIN_SCORE=3, three miss_right rallies → score_l=3, game_over=1, winner=0; a further miss_right → scores unchanged.
REQ-037 miss_left and miss_right in the same cycle during PLAY → scores unchanged, state POINT.
REQ-038 Assert reset during PLAY with score 2-1 → all outputs at reset values the same cycle (async), no ball_launch.
REQ-039 In OVER, hold start_btn high for 100 cycles → exactly one restart and scores 0-0; start_btn held through SERVE causes no second restart.
